// File: rtl/pwm_duty_ramp_if.sv
// rtl/pwm_duty_ramp_if.sv - target request handshake and duty output bundle
interface pwm_duty_ramp_if #(
  parameter int WIDTH = 16
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_duty;
  logic [WIDTH-1:0] tgt_step;
  logic [WIDTH-1:0] duty_out;
  logic             period_start;
  logic             busy;
  logic             done;

  modport master (
    output tgt_valid, tgt_duty, tgt_step,
    input  tgt_ready, duty_out, period_start, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_duty, tgt_step,
    output tgt_ready, duty_out, period_start, busy, done
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - slews the PWM compare word toward a target, one step per period
module pwm_duty_ramp #(
  parameter int WIDTH  = 16,
  parameter int PERIOD = 20000
) (
  input logic           clk,
  input logic           rst,
  pwm_duty_ramp_if.slave bus
);
  localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PERIOD - 1);

  typedef enum logic {
    IDLE,
    RAMP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] step_q;
  logic             period_start_q;
  logic             done_q;
  logic             boundary;
  logic [WIDTH:0]   diff;

  // The boundary edge is the last cycle of the period; every duty update lands here.
  assign boundary = (cnt == LAST_CNT);

  // Distance to target, one bit wider so it can never wrap.
  always_comb begin
    diff = '0;
    if (target_q >= duty_q) begin
      diff = {1'b0, target_q} - {1'b0, duty_q};
    end else begin
      diff = {1'b0, duty_q} - {1'b0, target_q};
    end
  end

  // Free-running period counter and the registered period_start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= boundary;
      cnt            <= boundary ? '0 : cnt + WIDTH'(1);
    end
  end

  // Request acceptance and per-period slewing of the compare word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= WIDTH'(1);
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Acceptance never steps on the same edge, even if that edge is a boundary.
          if (bus.tgt_valid) begin
            target_q <= (bus.tgt_duty > PERIOD_W) ? PERIOD_W : bus.tgt_duty;
            step_q   <= (bus.tgt_step == '0) ? WIDTH'(1) : bus.tgt_step;
            state    <= RAMP;
          end
        end
        RAMP: begin
          if (boundary) begin
            if (diff <= {1'b0, step_q}) begin
              duty_q <= target_q;
              done_q <= 1'b1;
              state  <= IDLE;
            end else if (target_q > duty_q) begin
              // diff > step here, so the sum stays below target and cannot overflow.
              duty_q <= duty_q + step_q;
            end else begin
              duty_q <= duty_q - step_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tgt_ready    = (state == IDLE);
  assign bus.busy         = (state == RAMP);
  assign bus.duty_out     = duty_q;
  assign bus.period_start = period_start_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - randomized and directed bench for pwm_duty_ramp against a behavioural model
module tb_pwm_duty_ramp;
  localparam int W = 16;
  localparam int P = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_duty_ramp_if #(.WIDTH(W)) bus ();

  pwm_duty_ramp #(.WIDTH(W), .PERIOD(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time since release, plus the current ramp goal.
  int m_k;
  int m_duty;
  int m_target;
  int m_step;
  bit m_busy;
  bit m_done;
  bit m_pstart;
  bit m_acc;

  int seen_q[$];
  int exp_q[$];
  int last_duty;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k      = 0;
    m_duty   = 0;
    m_target = 0;
    m_step   = 1;
    m_busy   = 0;
    m_done   = 0;
    m_pstart = 0;
    m_acc    = 0;
    last_duty = 0;
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic cycle();
    bit bnd;
    int d;
    @(posedge clk);
    bnd    = (m_k % P) == (P - 1);
    m_done = 0;
    m_acc  = 0;
    if (!m_busy) begin
      if (bus.tgt_valid) begin
        m_target = (int'(bus.tgt_duty) > P) ? P : int'(bus.tgt_duty);
        m_step   = (bus.tgt_step == 0) ? 1 : int'(bus.tgt_step);
        m_busy   = 1;
        m_acc    = 1;
      end
    end else if (bnd) begin
      d = (m_target > m_duty) ? m_target - m_duty : m_duty - m_target;
      if (d <= m_step) begin
        m_duty = m_target;
        m_done = 1;
        m_busy = 0;
      end else begin
        m_duty = (m_target > m_duty) ? m_duty + m_step : m_duty - m_step;
      end
    end
    m_pstart = bnd;
    m_k++;
    @(negedge clk);
    check_eq("duty_out", int'(bus.duty_out), m_duty);
    check_eq("period_start", int'(bus.period_start), int'(m_pstart));
    check_eq("done", int'(bus.done), int'(m_done));
    check_eq("busy", int'(bus.busy), int'(m_busy));
    check_eq("tgt_ready", int'(bus.tgt_ready), int'(!m_busy));
    check_eq("duty_le_period", int'(bus.duty_out <= P), 1);
    if (bus.period_start && (int'(bus.duty_out) != last_duty || bus.done))
      seen_q.push_back(int'(bus.duty_out));
    last_duty = int'(bus.duty_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a request and hold it until the model says it was taken.
  task automatic send(input int duty, input int step);
    int guard;
    bus.tgt_valid = 1'b1;
    bus.tgt_duty  = W'(duty);
    bus.tgt_step  = W'(step);
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!m_acc && guard < 400);
    bus.tgt_valid = 1'b0;
    if (!m_acc) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (m_busy && guard < 400) begin
      cycle();
      guard++;
    end
    if (m_busy) check_eq("done_timeout", 0, 1);
  endtask

  task automatic cmp_seq(input string tag);
    check_eq({tag, "_len"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      check_eq(tag, seen_q[i], exp_q[i]);
    seen_q.delete();
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_duty", int'(bus.duty_out), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_ready", int'(bus.tgt_ready), 1);
    check_eq("rst_pstart", int'(bus.period_start), 0);
    check_eq("rst_done", int'(bus.done), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_q.delete();
  endtask

  initial begin
    int guard;
    bus.tgt_valid = 1'b0;
    bus.tgt_duty  = '0;
    bus.tgt_step  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("init_duty", int'(bus.duty_out), 0);
    check_eq("init_ready", int'(bus.tgt_ready), 1);
    check_eq("init_busy", int'(bus.busy), 0);
    rst = 1'b0;

    // Tick: first period_start ten edges after release.
    idle(9);
    check_eq("no_early_pstart", int'(bus.period_start), 0);
    cycle();
    check_eq("first_pstart", int'(bus.period_start), 1);
    idle(15);

    // Ramp up 0 -> 7 by 3.
    seen_q.delete();
    send(7, 3);
    wait_done();
    exp_q = {3, 6, 7};
    cmp_seq("ramp_up");
    cycle();
    check_eq("busy_after_up", int'(bus.busy), 0);

    // Ramp down 7 -> 1 by 2, then same target again.
    send(1, 2);
    wait_done();
    exp_q = {5, 3, 1};
    cmp_seq("ramp_down");
    send(1, 2);
    wait_done();
    exp_q = {1};
    cmp_seq("same_target");

    // Clamp to PERIOD with a zero step.
    do_reset();
    send(50, 0);
    wait_done();
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    cmp_seq("clamp");

    // Held request during a ramp is taken at the edge ending the done cycle.
    do_reset();
    send(8, 4);
    bus.tgt_valid = 1'b1;
    bus.tgt_duty  = W'(4);
    bus.tgt_step  = W'(1);
    guard = 0;
    while (m_busy && guard < 400) begin
      cycle();
      check_eq("held_not_taken", int'(bus.tgt_ready), int'(!m_busy));
      guard++;
    end
    check_eq("done_cycle_ready", int'(bus.tgt_ready), 1);
    cycle();
    check_eq("held_taken", int'(bus.busy), 1);
    bus.tgt_valid = 1'b0;
    wait_done();
    exp_q = {4, 8, 7, 6, 5, 4};
    cmp_seq("held_req");

    // Acceptance on a boundary edge does not step on that edge.
    guard = 0;
    while ((m_k % P) != (P - 1) && guard < 20) begin
      cycle();
      guard++;
    end
    bus.tgt_valid = 1'b1;
    bus.tgt_duty  = W'(6);
    bus.tgt_step  = W'(2);
    cycle();
    bus.tgt_valid = 1'b0;
    check_eq("bnd_acc_pstart", int'(bus.period_start), 1);
    check_eq("bnd_acc_hold", int'(bus.duty_out), 4);
    wait_done();
    exp_q = {6};
    cmp_seq("bnd_acc");

    // Reset in the middle of a 0 -> 9 ramp once duty reaches 3.
    do_reset();
    send(9, 3);
    guard = 0;
    while (int'(bus.duty_out) != 3 && guard < 200) begin
      cycle();
      guard++;
    end
    check_eq("mid_reached3", int'(bus.duty_out), 3);
    do_reset();
    idle(25);

    // Randomized requests, gaps, early holds and occasional resets.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      idle($urandom_range(0, 12));
      send($urandom_range(0, 15), $urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) begin
        bus.tgt_valid = 1'b1;
        bus.tgt_duty  = W'($urandom_range(0, 15));
        bus.tgt_step  = W'($urandom_range(0, 6));
        guard = 0;
        do begin
          cycle();
          guard++;
        end while (!m_acc && guard < 400);
        bus.tgt_valid = 1'b0;
      end
      wait_done();
      seen_q.delete();
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
